// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: edge-triggered interrupt entry (push PC/CCR, load vector) and RTI return (pop CCR/PC) sequencer
module interrupt_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       intr_in,
    input  logic       inst_boundary,
    input  logic       rti_exec,
    input  logic [7:0] pc_in,
    input  logic [3:0] flags_in,
    input  logic [7:0] mem_data,
    output logic       stall_fetch,
    output logic       flush,
    output logic       sp_en,
    output logic       sp_op,
    output logic       mem_read,
    output logic       mem_write,
    output logic       vec_sel,
    output logic [7:0] data_out,
    output logic       stack_pc,
    output logic       stack_flags,
    output logic       flags_restore,
    output logic [3:0] flags_rest_val,
    output logic       pc_load,
    output logic [7:0] pc_load_val,
    output logic       int_active
);
    typedef enum logic [2:0] {IDLE, PUSH_PC, PUSH_FL, VEC_RD, VEC_LD, POP_FL, POP_PC, RET_LD} state_t;
    state_t     state, state_n;
    logic       pend, intr_q, armed, intr_edge, accept;
    logic [7:0] save_pc;
    logic [3:0] save_fl;
    // armed masks the first sample after reset so a level held through reset is not an edge
    assign intr_edge = armed & intr_in & ~intr_q;
    assign accept    = (state == IDLE) & ~rti_exec & pend & inst_boundary & ~int_active;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            intr_q     <= 1'b0;
            armed      <= 1'b0;
            pend       <= 1'b0;
            save_pc    <= 8'h00;
            save_fl    <= 4'h0;
            int_active <= 1'b0;
        end else begin
            intr_q <= intr_in;
            armed  <= 1'b1;
            pend   <= intr_edge | (pend & ~accept);
            if (accept) begin
                save_pc <= pc_in;
                save_fl <= flags_in;
            end
            if (state == VEC_LD)      int_active <= 1'b1;
            else if (state == RET_LD) int_active <= 1'b0;
        end
    end
    always_comb begin
        state_n        = state;
        stall_fetch    = state != IDLE;
        flush          = 1'b0;
        sp_en          = 1'b0;
        sp_op          = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        vec_sel        = 1'b0;
        data_out       = 8'h00;
        stack_pc       = 1'b0;
        stack_flags    = 1'b0;
        flags_restore  = 1'b0;
        flags_rest_val = 4'h0;
        pc_load        = 1'b0;
        pc_load_val    = 8'h00;
        case (state)
            IDLE: state_n = rti_exec ? POP_FL : accept ? PUSH_PC : IDLE;
            PUSH_PC: begin
                state_n   = PUSH_FL;
                flush     = 1'b1;
                sp_en     = 1'b1;
                mem_write = 1'b1;
                stack_pc  = 1'b1;
                data_out  = save_pc;
            end
            PUSH_FL: begin
                state_n     = VEC_RD;
                sp_en       = 1'b1;
                mem_write   = 1'b1;
                stack_flags = 1'b1;
                data_out    = {4'b0000, save_fl};
            end
            VEC_RD: begin
                state_n  = VEC_LD;
                mem_read = 1'b1;
                vec_sel  = 1'b1;
            end
            VEC_LD: begin
                state_n     = IDLE;
                pc_load     = 1'b1;
                pc_load_val = mem_data;
            end
            POP_FL: begin
                state_n     = POP_PC;
                flush       = 1'b1;
                sp_en       = 1'b1;
                sp_op       = 1'b1;
                mem_read    = 1'b1;
                stack_flags = 1'b1;
            end
            POP_PC: begin
                state_n        = RET_LD;
                flags_restore  = 1'b1;
                flags_rest_val = mem_data[3:0];
                sp_en          = 1'b1;
                sp_op          = 1'b1;
                mem_read       = 1'b1;
                stack_pc       = 1'b1;
            end
            RET_LD: begin
                state_n     = IDLE;
                pc_load     = 1'b1;
                pc_load_val = mem_data;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
